joy_serial_reader: RTL and testbench



---
 rtl/joy_serial_reader.sv | 134 +++++++++++++
 tb/tb_joy_serial_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
// Self-timed scanner for a 74HC165-style joystick chain: load, shift N bits MSB first, publish inverted.
// Optional JOY_PASSTHRU_EN adds ports that let an external scanner drive the chain instead.
module joy_serial_reader #(
  parameter int CHANNELS  = 2,
  parameter int BITS      = 12,
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       joy_clk,
  output logic                       joy_load,
  input  logic                       joy_data,
  output logic                       joy_select,
  output logic [CHANNELS*BITS-1:0]   joy_out,
  output logic                       joy_valid
`ifdef JOY_PASSTHRU_EN
  ,
  input  logic                       passthru_en,
  input  logic                       joy_xclk,
  input  logic                       joy_xload,
  output logic                       joy_xdata
`endif
);

  localparam int N     = CHANNELS * BITS;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_GAP      = 2'd0,
    S_LOAD     = 2'd1,
    S_SHIFT_LO = 2'd2,
    S_SHIFT_HI = 2'd3
  } state_t;

  state_t         state_q;
  logic [DIV_W-1:0] div_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] bit_q;
  logic [N-1:0]   shift_q;
  logic [N-1:0]   joy_out_q;
  logic           valid_q;
  logic           clk_q;
  logic           load_q;
  logic [1:0]     sync_q;
  logic           tick;
  logic           hold;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef JOY_PASSTHRU_EN
  // While the external scanner owns the chain the FSM parks in GAP with cleared counters.
  assign hold      = passthru_en;
  assign joy_clk   = passthru_en ? joy_xclk  : clk_q;
  assign joy_load  = passthru_en ? joy_xload : load_q;
  assign joy_xdata = joy_data;
`else
  assign hold      = 1'b0;
  assign joy_clk   = clk_q;
  assign joy_load  = load_q;
`endif

  assign joy_select = 1'b1;
  assign joy_out    = joy_out_q;
  assign joy_valid  = valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_GAP;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      joy_out_q <= '0;
      valid_q   <= 1'b0;
      clk_q     <= 1'b1;
      load_q    <= 1'b1;
      sync_q    <= 2'b11;
    end else begin
      sync_q  <= {sync_q[0], joy_data};
      valid_q <= 1'b0;
      if (hold) begin
        state_q <= S_GAP;
        div_q   <= '0;
        gap_q   <= '0;
        bit_q   <= '0;
        clk_q   <= 1'b1;
        load_q  <= 1'b1;
      end else begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          case (state_q)
            S_GAP: begin
              if (gap_q == GAP_W'(FRAME_GAP - 1)) begin
                gap_q   <= '0;
                load_q  <= 1'b0;
                state_q <= S_LOAD;
              end else begin
                gap_q <= gap_q + GAP_W'(1);
              end
            end
            S_LOAD: begin
              bit_q   <= '0;
              load_q  <= 1'b1;
              clk_q   <= 1'b0;
              state_q <= S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
              // Chain data is active low; store pressed as 1.
              shift_q <= N'({shift_q, ~sync_q[1]});
              bit_q   <= bit_q + CNT_W'(1);
              clk_q   <= 1'b1;
              state_q <= S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
              if (bit_q < CNT_W'(N)) begin
                clk_q   <= 1'b0;
                state_q <= S_SHIFT_LO;
              end else begin
                joy_out_q <= shift_q;
                valid_q   <= 1'b1;
                state_q   <= S_GAP;
              end
            end
            default: state_q <= S_GAP;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: 165-chain model, frame timing, scoreboard of published words, reset and passthru.
module tb_joy_serial_reader;

  localparam int N = 24;

  logic          clk;
  logic          reset_n;
  logic          joy_clk;
  logic          joy_load;
  logic          joy_data;
  logic          joy_select;
  logic [N-1:0]  joy_out;
  logic          joy_valid;
  logic          passthru_en;
  logic          joy_xclk;
  logic          joy_xload;
  logic          joy_xdata;

  logic [N-1:0]  raw;
  logic [N-1:0]  sreg;
  logic [N-1:0]  prev_out;
  logic          pt_data;
  int            mode;
  int            cyc;
  int            n_checks;
  int            n_errors;
  logic [N-1:0]  exp_q[$];

  joy_serial_reader #(.CHANNELS(2), .BITS(12), .CLK_DIV(4), .FRAME_GAP(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .joy_select (joy_select),
    .joy_out    (joy_out),
    .joy_valid  (joy_valid)
`ifdef JOY_PASSTHRU_EN
    ,
    .passthru_en(passthru_en),
    .joy_xclk   (joy_xclk),
    .joy_xload  (joy_xload),
    .joy_xdata  (joy_xdata)
`endif
  );

`ifndef JOY_PASSTHRU_EN
  assign joy_xdata = 1'b0;
`endif

  // Clock and reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // 74HC165 chain model: parallel load while low, shift toward QH on clock rise
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) sreg <= raw;
    else           sreg <= {sreg[N-2:0], 1'b1};
  end

  assign joy_data = (mode == 0) ? sreg[N-1] :
                    (mode == 1) ? 1'b1 :
                    (mode == 2) ? 1'b0 : pt_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop on every valid pulse; joy_out must hold otherwise
  always @(negedge clk) begin
    if (reset_n) begin
      if (joy_valid) begin
        if (exp_q.size() == 0) check("valid_unexpected", 32'(exp_q.size()), 32'd1);
        else                   check("frame_data", 32'(joy_out), 32'(exp_q.pop_front()));
      end else if (joy_out !== prev_out) begin
        check("out_hold", 32'(joy_out), 32'(prev_out));
      end
    end
    prev_out = joy_out;
  end

  task automatic wait_load_fall(output int c);
    c = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!joy_load) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("load_timeout", 32'(joy_load), 32'd0);
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (joy_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("valid_timeout", 32'(joy_valid), 32'd1);
  endtask

  task automatic count_rises(input int n);
    int   seen;
    logic prev;
    seen = 0;
    prev = joy_clk;
    for (int i = 0; i < 2000 && seen < n; i++) begin
      @(negedge clk);
      if (!prev && joy_clk) seen++;
      prev = joy_clk;
    end
    if (seen < n) check("rise_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w;
    int t;
    int t0;
    n_checks    = 0;
    n_errors    = 0;
    mode        = 0;
    raw         = 24'h5AF00F;
    pt_data     = 1'b1;
    passthru_en = 1'b0;
    joy_xclk    = 1'b1;
    joy_xload   = 1'b1;
    reset_n     = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_clk",    32'(joy_clk),    32'd1);
    check("rst_load",   32'(joy_load),   32'd1);
    check("rst_select", 32'(joy_select), 32'd1);
    check("rst_out",    32'(joy_out),    32'h0);
    check("rst_valid",  32'(joy_valid),  32'd0);

    // Frame 1: timing of load, shift pulses and publish
    exp_q.push_back(~24'h5AF00F);
    reset_n = 1'b1;
    wait_load_fall(c);
    check("load_fall_cyc", 32'(c), 32'd32);
    w = 0;
    while (!joy_load && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("load_width", 32'(w), 32'd4);
    for (int p = 0; p < N; p++) begin
      t = 0;
      while (joy_clk && t < 100) begin
        @(negedge clk);
        t++;
      end
      w = 0;
      while (!joy_clk && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("clk_low_width", 32'(w), 32'd4);
    end
    wait_valid(c);
    check("valid1_cyc", 32'(c), 32'd228);

    exp_q.push_back(~24'h5AF00F);
    wait_valid(c);
    check("valid2_cyc", 32'(c), 32'd456);

    // Constant line levels
    mode = 1;
    exp_q.push_back(24'h000000);
    wait_valid(c);
    check("valid3_cyc", 32'(c), 32'd684);
    mode = 2;
    exp_q.push_back(24'hFFFFFF);
    wait_valid(c);

    // Reset mid-frame: partial frame must be dropped
    mode = 0;
    raw  = 24'h123456;
    wait_load_fall(c);
    count_rises(10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out",   32'(joy_out),   32'h0);
    check("midrst_valid", 32'(joy_valid), 32'd0);
    check("midrst_clk",   32'(joy_clk),   32'd1);
    check("midrst_load",  32'(joy_load),  32'd1);
    repeat (3) @(negedge clk);
    exp_q.push_back(~24'h123456);
    reset_n = 1'b1;
    wait_load_fall(c);
    check("midrst_load_cyc", 32'(c), 32'd32);
    wait_valid(c);
    check("midrst_valid_cyc", 32'(c), 32'd228);

`ifdef JOY_PASSTHRU_EN
    mode = 3;
    @(negedge clk);
    passthru_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      joy_xclk  = 1'($urandom_range(0, 1));
      joy_xload = 1'($urandom_range(0, 1));
      pt_data   = 1'($urandom_range(0, 1));
      #1;
      check("pt_clk",   32'(joy_clk),   32'(joy_xclk));
      check("pt_load",  32'(joy_load),  32'(joy_xload));
      check("pt_xdata", 32'(joy_xdata), 32'(pt_data));
    end
    joy_xclk  = 1'b1;
    joy_xload = 1'b1;
    @(negedge clk);
    passthru_en = 1'b0;
    t0 = cyc;
    wait_load_fall(c);
    check("pt_restart_load", 32'(c - t0), 32'd32);
    mode = 0;
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
